// File: rtl/cache_line_mover.sv
// cache_line_mover
// Cache-side bus master for one cache (I or D). It takes a single-cycle
// fill or writeback command, drives the tagged request beats toward the
// arbiter, and gathers the tagged response beats back into a whole line.
//
// Ports
//   clk, reset                 clock; asynchronous active-low reset
//   cmd_valid/cmd_write        command strobe; 1 = writeback, 0 = fill
//   cmd_addr, cmd_wdata        line address and writeback line (beat 0 in LSBs)
//   cmd_ready, done            idle indicator; one-cycle completion pulse
//   fill_data                  assembled fill line (beat 0 in LSBs)
//   req/reqtag/reqcyc/reqack   request beat channel toward the arbiter
//   resp/resptag/respcyc/respack response beat channel from the arbiter
module cache_line_mover #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 13,
    parameter int LINE_BEATS = 8,
    parameter int IS_INST    = 0,
    parameter int CLIENT_ID  = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cmd_valid,
    input  logic                             cmd_write,
    input  logic [DATA_WIDTH-1:0]            cmd_addr,
    input  logic [DATA_WIDTH*LINE_BEATS-1:0] cmd_wdata,
    output logic                             cmd_ready,
    output logic                             done,
    output logic [DATA_WIDTH*LINE_BEATS-1:0] fill_data,
    output logic [DATA_WIDTH-1:0]            req,
    output logic [TAG_WIDTH-1:0]             reqtag,
    output logic                             reqcyc,
    input  logic                             reqack,
    input  logic [DATA_WIDTH-1:0]            resp,
    input  logic [TAG_WIDTH-1:0]             resptag,
    input  logic                             respcyc,
    output logic                             respack
);
    localparam int CW = $clog2(LINE_BEATS);
    localparam logic [CW-1:0] LAST = CW'(LINE_BEATS - 1);

    // Tag: [12] read/write, [11:8] memory target, [7] I/D cache, [6:0] client.
    localparam logic [12:0] RD_TAG13 = {1'b1, 4'b0001, 1'(IS_INST), 7'(CLIENT_ID)};
    localparam logic [12:0] WR_TAG13 = {1'b0, 4'b0001, 1'(IS_INST), 7'(CLIENT_ID)};
    localparam logic [TAG_WIDTH-1:0] RD_TAG = TAG_WIDTH'(RD_TAG13);
    localparam logic [TAG_WIDTH-1:0] WR_TAG = TAG_WIDTH'(WR_TAG13);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, DONE} state_t;

    state_t                                 state, state_nxt;
    logic [CW-1:0]                          cnt;
    logic [DATA_WIDTH-1:0]                  addr_q;
    logic [LINE_BEATS-1:0][DATA_WIDTH-1:0]  wline_q;
    logic [LINE_BEATS-1:0][DATA_WIDTH-1:0]  fline_q;

    // Qualified by reset so the cache never sees ready while held in reset.
    assign cmd_ready = (state == IDLE) && reset;
    assign fill_data = fline_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Request outputs decode straight from the state flop, so they are
    // glitch-free and hold steady across any number of stalled cycles.
    always_comb begin
        state_nxt = state;
        reqcyc    = 1'b0;
        req       = '0;
        reqtag    = '0;
        respack   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (cmd_valid) state_nxt = cmd_write ? WR_ADDR : RD_ADDR;
            RD_ADDR: begin
                reqcyc = 1'b1;
                req    = addr_q;
                reqtag = RD_TAG;
                if (reqack) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                // Beats carrying another client's tag are left for that client.
                respack = respcyc && (resptag == RD_TAG);
                if (respack && cnt == LAST) state_nxt = DONE;
            end
            WR_ADDR: begin
                reqcyc = 1'b1;
                req    = addr_q;
                reqtag = WR_TAG;
                if (reqack) state_nxt = WR_DATA;
            end
            WR_DATA: begin
                reqcyc = 1'b1;
                req    = wline_q[cnt];
                reqtag = WR_TAG;
                if (reqack && cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat counter wraps to 0 on the last beat because LINE_BEATS is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            fline_q <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    addr_q  <= cmd_addr;
                    wline_q <= cmd_wdata;
                    cnt     <= '0;
                end
                RD_DATA: if (respack) begin
                    fline_q[cnt] <= resp;
                    cnt          <= cnt + 1'b1;
                end
                WR_ADDR: if (reqack) cnt <= '0;
                WR_DATA: if (reqack) cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/cache_line_mover.md
Name: cache_line_mover

Overview:
Cache-side bus master that drives the CachePorts side of the arbiter/cache bus on behalf of one cache (I or D). Converts a single-cycle line-fill or line-writeback command from cache control into the tagged request/response beat protocol. Buffers a full line: assembles fill beats into a line register and serialises writeback data into beats. Sits directly upstream of the arbiter.

Parameters:
DATA_WIDTH, 64, bus beat width
TAG_WIDTH, 13, bus tag width
LINE_BEATS, 8, beats per cache line (power of two, >=2)
IS_INST, 0, tag bit 7 value (1 = instruction cache, 0 = data cache)
CLIENT_ID, 0, 7-bit value placed in tag[6:0]

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low (0 = in reset)
cmd_valid  in  1  start command (sampled only when cmd_ready=1)
cmd_write  in  1  1 = writeback, 0 = fill
cmd_addr  in  DATA_WIDTH  line-aligned physical address
cmd_wdata  in  DATA_WIDTH*LINE_BEATS  writeback line, beat 0 in LSBs
cmd_ready  out  1  high only in IDLE
done  out  1  one-cycle pulse at completion
fill_data  out  DATA_WIDTH*LINE_BEATS  assembled fill line, valid when done=1 after a fill
req  out  DATA_WIDTH  request beat
reqtag  out  TAG_WIDTH  request tag
reqcyc  out  1  request beat valid
reqack  in  1  arbiter accepted beat
resp  in  DATA_WIDTH  response beat
resptag  in  TAG_WIDTH  response tag
respcyc  in  1  response beat valid
respack  out  1  response beat consumed

Behaviour:
- Tag layout: [12]=READ(1)/WRITE(0); [11:8]=0001 (MEMORY); [7]=IS_INST; [6:0]=CLIENT_ID.
- Request beat transfers on a cycle with reqcyc=1 and reqack=1. Once reqcyc is raised, req/reqtag stay stable until that transfer.
- Response beat transfers on a cycle with respcyc=1 and respack=1. respack is combinational: respack = (state==RD_DATA) & respcyc & (resptag == expected READ tag).
- A response with a non-matching resptag is never acked and never written; it belongs to another client.
- Reset (async, reset=0): state=IDLE, beat counter=0, reqcyc=0, respack=0, done=0, cmd_ready=0 during reset, req=0, reqtag=0, fill_data=0. cmd_ready goes to 1 in IDLE after reset deasserts.
- Reset mid-transfer abandons the operation immediately. No done pulse is generated, and the line buffer is cleared.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, DONE.
- IDLE:
  - cmd_valid=1 latches cmd_addr, cmd_write and cmd_wdata, and clears the counter.
  - Goes to WR_ADDR if cmd_write=1, else RD_ADDR.
  - Commands are accepted only in IDLE; cmd_valid in any other state is ignored.
- RD_ADDR: reqcyc=1, req=addr, reqtag=READ tag. On reqack go to RD_DATA.
- RD_DATA:
  - Each response transfer writes resp into line slice[counter] and increments counter.
  - The transfer with counter==LINE_BEATS-1 goes to DONE, and the counter wraps to 0.
  - respcyc low stalls indefinitely; there is no timeout.
- WR_ADDR: reqcyc=1, req=addr, reqtag=WRITE tag. On reqack go to WR_DATA with counter=0.
- WR_DATA:
  - reqcyc=1, req=wdata slice[counter], reqtag=WRITE tag.
  - Each reqack increments counter; the ack at counter==LINE_BEATS-1 goes to DONE.
  - No response is expected for writes.
- DONE: done=1 for exactly one cycle, reqcyc=0, then go to IDLE.
- Minimum latency:
  - Fill: cmd accept -> done = LINE_BEATS+3 cycles (acks immediate, back-to-back responses).
  - Writeback: same, LINE_BEATS+3 cycles.
- reqcyc is registered and drops the cycle after the final accepted beat. The next beat is presented in the cycle after each ack, so beats are back-to-back with no bubble.
- fill_data holds its value until the next fill's first beat overwrites slice 0.
- respack is never asserted outside RD_DATA, even if respcyc=1.

Test Plan:
- Fill, immediate ack, back-to-back matching responses 0x11..0x88 -> one address beat with req=cmd_addr and reqtag=0x1100|{IS_INST,CLIENT_ID}; fill_data beat i = 0x11*(i+1); done after exactly 11 cycles.
- Writeback with line words 0xA0..0xA7 and reqack held low 3 cycles per beat -> req/reqtag stable while stalled; 9 transfers in order (addr, 0xA0..0xA7), reqtag[12]=0; single done pulse.
- Response tagged CLIENT_ID+1 interleaved with own beats -> foreign beat gets respack=0 and is not stored; own 8 beats are assembled correctly.
- cmd_valid with cmd_write=1 asserted during RD_DATA -> ignored; cmd_ready=0; no write beats are issued after the fill completes.
- reset=0 asserted at beat 4 of a fill -> reqcyc, respack and done go to 0 asynchronously; after release, state is IDLE with cmd_ready=1, and a new fill completes normally.
- respcyc=1 with matching tag while in RD_ADDR (before reqack) -> respack=0 and the beat is not stored.
